adder_bist: RTL and testbench

- Synthesizable built-in self-test controller for the 6-bit ripple adder. It sits on the opposite side of the adder's `x`/`y`/`s` interface: it drives the operands and checks the result.
- On `start` it sweeps all 4096 operand pairs, with `x` outer and `y` inner.
- After each vector it compares the adder's `s` with an internal `x+y`, counts mismatches, captures the first failing vector, and reports pass/fail.
- It replaces the simulation-only exhaustive check for on-silicon and gate-level use.

---
 rtl/adder_bist_pkg.sv | 21 ++
 rtl/bist_vector_gen.sv | 46 ++++
 rtl/adder_bist.sv | 149 ++++++++++++++
 tb/tb_adder_bist.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_bist_pkg.sv
// Shared types, constants and reference arithmetic for the ripple-adder
// built-in self-test controller.
package adder_bist_pkg;

  localparam int WIDTH       = 6;
  localparam int NUM_VECTORS = 1 << (2 * WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Full-precision sum the adder under test must produce.
  function automatic logic [WIDTH:0] ref_sum(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/bist_vector_gen.sv
// Operand-pair counter for the adder self-test: index = {x, y}, y is the
// fast-moving half so it wraps into an x increment.
module bist_vector_gen
  import adder_bist_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             advance_i,
  output logic [WIDTH-1:0] x_o,
  output logic [WIDTH-1:0] y_o,
  output logic             last_o
);

  localparam logic [2*WIDTH-1:0] IDX_ZERO = {(2*WIDTH){1'b0}};
  localparam logic [2*WIDTH-1:0] IDX_ONE  = {{(2*WIDTH-1){1'b0}}, 1'b1};

  logic [2*WIDTH-1:0] idx_q;
  logic [2*WIDTH-1:0] idx_d;

  // Next index: clear wins over advance, otherwise hold.
  always_comb begin
    idx_d = idx_q;
    if (clear_i) begin
      idx_d = IDX_ZERO;
    end else if (advance_i) begin
      idx_d = idx_q + IDX_ONE;
    end else begin
      idx_d = idx_q;
    end
  end

  // Index register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q <= IDX_ZERO;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign x_o    = idx_q[2*WIDTH-1:WIDTH];
  assign y_o    = idx_q[WIDTH-1:0];
  assign last_o = &idx_q;

endmodule

// File: rtl/adder_bist.sv
// Exhaustive self-test controller for the ripple adder: drives x/y, checks s
// against the reference sum and reports mismatch count and first failure.
module adder_bist
  import adder_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int ERR_W         = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  input  logic [WIDTH:0]   s,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] first_err_x,
  output logic [WIDTH-1:0] first_err_y,
  output logic [WIDTH:0]   first_err_s
);

  localparam int              CNT_W     = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [ERR_W-1:0] ERR_ZERO = {ERR_W{1'b0}};
  localparam logic [ERR_W-1:0] ERR_ONE  = {{(ERR_W-1){1'b0}}, 1'b1};
  // With no settle time every vector is a single CHECK cycle.
  localparam state_e VEC_ENTRY = (SETTLE_CYCLES > 0) ? APPLY : CHECK;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [ERR_W-1:0] err_q;
  logic [WIDTH-1:0] fx_q;
  logic [WIDTH-1:0] fy_q;
  logic [WIDTH:0]   fs_q;

  logic             accept_s;
  logic             advance_s;
  logic             mismatch_s;
  logic             last_s;
  logic [WIDTH-1:0] x_s;
  logic [WIDTH-1:0] y_s;

  bist_vector_gen u_vec (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (accept_s),
    .advance_i(advance_s),
    .x_o      (x_s),
    .y_o      (y_s),
    .last_o   (last_s)
  );

  // Start acceptance, counter advance and result comparison.
  always_comb begin
    accept_s   = 1'b0;
    advance_s  = 1'b0;
    mismatch_s = (s != ref_sum(x_s, y_s));
    if ((state_q == IDLE) || (state_q == DONE)) begin
      accept_s = start;
    end else begin
      accept_s = 1'b0;
    end
    if ((state_q == CHECK) && !last_s) begin
      advance_s = 1'b1;
    end else begin
      advance_s = 1'b0;
    end
  end

  // Sweep sequencer with settle counter, error tally and status flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= CNT_ZERO;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= ERR_ZERO;
      fx_q    <= {WIDTH{1'b0}};
      fy_q    <= {WIDTH{1'b0}};
      fs_q    <= {(WIDTH+1){1'b0}};
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= VEC_ENTRY;
            cnt_q   <= CNT_ZERO;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= ERR_ZERO;
            fx_q    <= {WIDTH{1'b0}};
            fy_q    <= {WIDTH{1'b0}};
            fs_q    <= {(WIDTH+1){1'b0}};
          end
        end
        APPLY: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= CNT_ZERO;
            state_q <= CHECK;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        CHECK: begin
          if (mismatch_s) begin
            err_q <= err_q + ERR_ONE;
            if (err_q == ERR_ZERO) begin
              fx_q <= x_s;
              fy_q <= y_s;
              fs_q <= s;
            end
          end
          if (last_s) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_q == ERR_ZERO) && !mismatch_s;
          end else begin
            state_q <= VEC_ENTRY;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign x           = x_s;
  assign y           = y_s;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign err_count   = err_q;
  assign first_err_x = fx_q;
  assign first_err_y = fy_q;
  assign first_err_s = fs_q;

endmodule

// File: tb/tb_adder_bist.sv
// Self-checking bench for adder_bist: three instances (settle 1, 0, 3) driven
// by a fault-injectable behavioural adder and checked against a sweep model.
module tb_adder_bist;

  localparam int N = 4096;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] start_v;
  int         fbit = -1;
  logic       fval = 1'b0;
  bit         chk_en = 1'b0;

  logic [5:0]  x_v [3];
  logic [5:0]  y_v [3];
  logic [6:0]  s_v [3];
  logic        busy_v [3];
  logic        done_v [3];
  logic        pass_v [3];
  logic [12:0] err_v [3];
  logic [5:0]  fx_v [3];
  logic [5:0]  fy_v [3];
  logic [6:0]  fs_v [3];

  bit          m_run  [3];
  bit          m_done [3];
  bit          m_pass [3];
  int          m_k    [3];
  int          m_err  [3];
  logic [5:0]  m_x    [3];
  logic [5:0]  m_y    [3];
  logic [5:0]  m_fx   [3];
  logic [5:0]  m_fy   [3];
  logic [6:0]  m_fs   [3];

  int n_checks = 0;
  int n_err    = 0;
  int cyc_r [3];

  always #5 clk = ~clk;

  function automatic int s_of(input int i);
    case (i)
      0:       return 1;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  // Adder under test: true sum with an optional stuck-at bit.
  function automatic logic [6:0] adder_out(input logic [5:0] a, input logic [5:0] b,
                                           input int fb, input logic fv);
    logic [6:0] r;
    r = 7'(int'(a) + int'(b));
    if (fb >= 0 && fb <= 6) r[fb] = fv;
    return r;
  endfunction

  assign s_v[0] = adder_out(x_v[0], y_v[0], fbit, fval);
  assign s_v[1] = adder_out(x_v[1], y_v[1], fbit, fval);
  assign s_v[2] = adder_out(x_v[2], y_v[2], fbit, fval);

  adder_bist #(.SETTLE_CYCLES(1), .ERR_W(13)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .x(x_v[0]), .y(y_v[0]), .s(s_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .err_count(err_v[0]),
    .first_err_x(fx_v[0]), .first_err_y(fy_v[0]), .first_err_s(fs_v[0]));

  adder_bist #(.SETTLE_CYCLES(0), .ERR_W(13)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .x(x_v[1]), .y(y_v[1]), .s(s_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .err_count(err_v[1]),
    .first_err_x(fx_v[1]), .first_err_y(fy_v[1]), .first_err_s(fs_v[1]));

  adder_bist #(.SETTLE_CYCLES(3), .ERR_W(13)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .x(x_v[2]), .y(y_v[2]), .s(s_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .err_count(err_v[2]),
    .first_err_x(fx_v[2]), .first_err_y(fy_v[2]), .first_err_s(fs_v[2]));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Sweep model: elapsed cycles since start decide the vector; a vector is
  // judged when its SETTLE+1 cycles have elapsed.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      int sp;
      int v;
      logic [5:0] a;
      logic [5:0] b;
      logic [6:0] o;
      sp = s_of(i) + 1;
      if (!rst_n) begin
        m_run[i] = 0; m_done[i] = 0; m_pass[i] = 0; m_k[i] = 0; m_err[i] = 0;
        m_x[i] = 6'd0; m_y[i] = 6'd0; m_fx[i] = 6'd0; m_fy[i] = 6'd0; m_fs[i] = 7'd0;
      end else if (m_run[i]) begin
        m_k[i]++;
        if (m_k[i] % sp == 0) begin
          v = m_k[i] / sp - 1;
          a = 6'(v / 64);
          b = 6'(v % 64);
          o = adder_out(a, b, fbit, fval);
          if (int'(o) != int'(a) + int'(b)) begin
            if (m_err[i] == 0) begin
              m_fx[i] = a; m_fy[i] = b; m_fs[i] = o;
            end
            m_err[i]++;
          end
          if (v == N - 1) begin
            m_run[i] = 0; m_done[i] = 1; m_pass[i] = (m_err[i] == 0);
          end
        end
        if (m_run[i]) begin
          m_x[i] = 6'((m_k[i] / sp) / 64);
          m_y[i] = 6'((m_k[i] / sp) % 64);
        end
      end else if (start_v[i]) begin
        m_run[i] = 1; m_done[i] = 0; m_pass[i] = 0; m_k[i] = 0; m_err[i] = 0;
        m_x[i] = 6'd0; m_y[i] = 6'd0; m_fx[i] = 6'd0; m_fy[i] = 6'd0; m_fs[i] = 7'd0;
      end
    end
  end

  // Every-cycle comparison of all three instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("cycle_dut%0d", i),
              {busy_v[i], done_v[i], pass_v[i], err_v[i], fx_v[i], fy_v[i], fs_v[i], x_v[i], y_v[i]},
              {m_run[i], m_done[i], m_pass[i], 13'(m_err[i]), m_fx[i], m_fy[i], m_fs[i], m_x[i], m_y[i]});
        check($sformatf("busy_done_excl%0d", i), 64'(busy_v[i] & done_v[i]), 64'd0);
      end
    end
  end

  task automatic pulse_start(input logic [2:0] m);
    @(negedge clk);
    start_v = m;
    @(negedge clk);
    start_v = 3'b000;
  endtask

  // Runs until every masked instance shows done; optional start pulses on
  // instance 0 at elapsed cycles p1/p2.
  task automatic wait_done(input logic [2:0] mask, input int p1, input int p2);
    int n;
    logic [2:0] seen;
    n = 0;
    seen = 3'b000;
    for (int i = 0; i < 3; i++) cyc_r[i] = -1;
    while (((seen & mask) != mask) && (n < 20000)) begin
      @(posedge clk);
      n++;
      #1;
      start_v = 3'b000;
      if (n == p1 || n == p2) start_v[0] = 1'b1;
      for (int i = 0; i < 3; i++) begin
        if (mask[i] && !seen[i] && done_v[i]) begin
          seen[i] = 1'b1;
          cyc_r[i] = n;
        end
      end
    end
    start_v = 3'b000;
    check("done_reached", 64'(seen & mask), 64'(mask));
    @(negedge clk);
  endtask

  task automatic check_result(input string tag, input int cyc, input int err,
                              input logic ps, input int fx, input int fy, input int fs);
    check({tag, "_cycles"}, 64'(cyc_r[0]), 64'(cyc));
    check({tag, "_err"}, 64'(err_v[0]), 64'(err));
    check({tag, "_model_err"}, 64'(m_err[0]), 64'(err));
    check({tag, "_pass"}, 64'(pass_v[0]), 64'(ps));
    check({tag, "_first"}, {40'd0, fx_v[0], fy_v[0], fs_v[0]},
          {40'd0, 6'(fx), 6'(fy), 7'(fs)});
    check({tag, "_xy_hold"}, {52'd0, x_v[0], y_v[0]}, {52'd0, 6'd63, 6'd63});
  endtask

  initial begin
    int exp_cnt;
    logic [6:0] o;
    rst_n = 1'b0;
    start_v = 3'b000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    check("reset_outputs",
          {busy_v[0], done_v[0], pass_v[0], err_v[0], fx_v[0], fy_v[0], fs_v[0], x_v[0], y_v[0]}, 64'd0);
    rst_n = 1'b1;

    // Golden adder on all three settle settings.
    fbit = -1;
    pulse_start(3'b111);
    wait_done(3'b111, 0, 0);
    check_result("golden", 8192, 0, 1'b1, 0, 0, 0);
    check("golden_s0_cycles", 64'(cyc_r[1]), 64'd4096);
    check("golden_s3_cycles", 64'(cyc_r[2]), 64'd16384);
    check("golden_s0_pass", {62'd0, pass_v[1], done_v[1]}, 64'd3);
    check("golden_s3_pass", {62'd0, pass_v[2], done_v[2]}, 64'd3);

    // s[0] stuck-at-0, extra starts while busy, then restart from DONE.
    fbit = 0; fval = 1'b0;
    pulse_start(3'b001);
    wait_done(3'b001, 10, 5000);
    check_result("s0sa0", 8192, 2048, 1'b0, 0, 1, 0);
    pulse_start(3'b001);
    check("restart_clear", {48'd0, busy_v[0], done_v[0], err_v[0]}, {48'd0, 1'b1, 1'b0, 13'd0});
    wait_done(3'b001, 0, 0);
    check_result("s0sa0_again", 8192, 2048, 1'b0, 0, 1, 0);

    // s[6] stuck-at-0: every carry-out vector fails.
    fbit = 6; fval = 1'b0;
    pulse_start(3'b001);
    wait_done(3'b001, 0, 0);
    check_result("s6sa0", 8192, 2016, 1'b0, 1, 63, 0);

    // Mid-sweep reset aborts, then a clean sweep.
    fbit = -1;
    pulse_start(3'b001);
    repeat (3000) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset_outputs",
          {busy_v[0], done_v[0], pass_v[0], err_v[0], fx_v[0], fy_v[0], fs_v[0], x_v[0], y_v[0]}, 64'd0);
    rst_n = 1'b1;
    pulse_start(3'b001);
    wait_done(3'b001, 0, 0);
    check_result("after_reset", 8192, 0, 1'b1, 0, 0, 0);

    // Random stuck-at faults with a random ignored start pulse.
    for (int r = 0; r < 2; r++) begin
      fbit = int'($urandom_range(0, 6));
      fval = 1'($urandom_range(0, 1));
      exp_cnt = 0;
      for (int a = 0; a < 64; a++) begin
        for (int b = 0; b < 64; b++) begin
          o = adder_out(6'(a), 6'(b), fbit, fval);
          if (int'(o) != a + b) exp_cnt++;
        end
      end
      pulse_start(3'b001);
      wait_done(3'b001, int'($urandom_range(1, 8000)), 0);
      check($sformatf("rand%0d_err_b%0d_v%0d", r, fbit, fval), 64'(err_v[0]), 64'(exp_cnt));
      check($sformatf("rand%0d_pass", r), 64'(pass_v[0]), 64'(exp_cnt == 0));
      check($sformatf("rand%0d_cycles", r), 64'(cyc_r[0]), 64'd8192);
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
